hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_cmp.sv | 23 ++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core package: hazard FSM state encoding, default register-index width
// and pipeline stage-register widths used across the core.
package hazard_ctrl_pkg;

  localparam int REGFILE_LEN_DEFAULT = 6;
  localparam int FPU_CNT_W           = 4;
  localparam int STATE_W             = 1;

  // Stage-register payload widths (pc + instruction, decoded operands + control)
  localparam int IF_ID_W = 64;
  localparam int ID_EX_W = 128;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 1'b0,
    FPU_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Load-use comparator: flags an ID source that depends on the load in EX.
module hazard_cmp #(
  parameter int W = 6
) (
  input  logic [W-1:0] id_rs1,
  input  logic [W-1:0] id_rs2,
  input  logic         id_uses_rs1,
  input  logic         id_uses_rs2,
  input  logic [W-1:0] ex_rd,
  input  logic         ex_reg_write,
  input  logic         ex_mem_read,
  output logic         load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is never a real dependency
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush and, when
// HAZARD_FPU_MULTICYCLE_EN is defined, a multi-cycle FPU hold of the EX stage.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REGFILE_LEN = REGFILE_LEN_DEFAULT,
  parameter int FPU_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REGFILE_LEN-1:0] id_rs1,
  input  logic [REGFILE_LEN-1:0] id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REGFILE_LEN-1:0] ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_fpu_start,
  input  logic                   ex_redirect,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_hold,
  output logic [STATE_W-1:0]     dbg_state
);

  logic load_use;
  logic fsm_hold;

  hazard_cmp #(.W(REGFILE_LEN)) u_cmp (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .load_use     (load_use)
  );

`ifdef HAZARD_FPU_MULTICYCLE_EN
  localparam int WAIT_INT = (FPU_LATENCY > 2) ? (FPU_LATENCY - 2) : 0;
  localparam logic [FPU_CNT_W-1:0] WAIT_CYCLES = FPU_CNT_W'(WAIT_INT);

  hz_state_e              state_q, state_d;
  logic [FPU_CNT_W-1:0]   fpu_cnt_q, fpu_cnt_d;
  logic                   fpu_done_q, fpu_done_d;
  logic                   fpu_go;

  // ex_fpu_start stays high on the release cycle; fpu_done_q keeps it from retriggering
  assign fpu_go    = (FPU_LATENCY > 1) && ex_fpu_start && !ex_redirect && !fpu_done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fpu_cnt_q  <= '0;
      fpu_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpu_cnt_q  <= fpu_cnt_d;
      fpu_done_q <= fpu_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fpu_cnt_d  = fpu_cnt_q;
    fpu_done_d = 1'b0;
    fsm_hold   = 1'b0;
    case (state_q)
      RUN: begin
        if (fpu_go) begin
          fsm_hold = 1'b1;
          if (FPU_LATENCY > 2) begin
            state_d   = FPU_WAIT;
            fpu_cnt_d = WAIT_CYCLES;
          end else begin
            fpu_done_d = 1'b1;
          end
        end
      end
      FPU_WAIT: begin
        fsm_hold = 1'b1;
        if (fpu_cnt_q <= FPU_CNT_W'(1)) begin
          state_d    = RUN;
          fpu_cnt_d  = '0;
          fpu_done_d = 1'b1;
        end else begin
          fpu_cnt_d = fpu_cnt_q - FPU_CNT_W'(1);
        end
      end
      default: begin
        state_d   = RUN;
        fpu_cnt_d = '0;
      end
    endcase
  end
`else
  logic [2:0] unused_sig;

  assign unused_sig = {clk, ex_fpu_start, FPU_LATENCY[0]};
  assign fsm_hold   = 1'b0;
  assign dbg_state  = RUN;
`endif

  // Priority: reset, FPU hold, redirect, load-use stall
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (fsm_hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_hold     = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; FPU-wait vectors are built only when
// HAZARD_FPU_MULTICYCLE_EN is defined, otherwise the single-cycle FPU path is checked.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int RL = REGFILE_LEN_DEFAULT;

  // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_hold}
  localparam logic [5:0] O_RUN   = 6'b111_00_0;
  localparam logic [5:0] O_STALL = 6'b001_01_0;
  localparam logic [5:0] O_REDIR = 6'b111_11_0;
  localparam logic [5:0] O_HOLD  = 6'b000_00_1;
  localparam logic [5:0] O_RST   = 6'b000_11_0;

  logic          clk;
  logic          rst_n;
  logic [RL-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic          ex_reg_write, ex_mem_read, ex_fpu_start, ex_redirect;
  logic          pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_hold;
  logic [STATE_W-1:0] dbg_state;

  int n_vec;
  int n_fail;

  hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_fpu_start (ex_fpu_start),
    .ex_redirect  (ex_redirect),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_write  (id_ex_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_hold      (ex_hold),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // drivers: set inputs just after a rising edge, then check outputs at the falling edge
  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_fpu_start = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic drive_ex(input logic [RL-1:0] rd, input logic mem_rd, input logic reg_wr);
    ex_rd = rd; ex_mem_read = mem_rd; ex_reg_write = reg_wr;
  endtask

  task automatic drive_id(input logic [RL-1:0] rs1, input logic u1,
                          input logic [RL-1:0] rs2, input logic u2);
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] exp);
    @(negedge clk);
    check(tag, {2'b00, pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_hold},
          {2'b00, exp});
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    drive_idle();
    rst_n = 1'b0;

    next_cycle();
    expect_out("reset_out", O_RST);
    next_cycle();
    expect_out("reset_out2", O_RST);
    rst_n = 1'b1;
    next_cycle();
    expect_out("idle_run", O_RUN);

    // lw x5 in EX, add reading x5 on rs1 -> one stall, then bubble in EX
    drive_ex(6'd5, 1'b1, 1'b1);
    drive_id(6'd5, 1'b1, 6'd7, 1'b1);
    expect_out("load_use_rs1", O_STALL);
    next_cycle();
    drive_ex(6'd0, 1'b0, 1'b0);
    expect_out("after_bubble", O_RUN);

    next_cycle();
    drive_ex(6'd9, 1'b1, 1'b1);
    drive_id(6'd3, 1'b1, 6'd9, 1'b1);
    expect_out("load_use_rs2", O_STALL);

    next_cycle();
    drive_id(6'd9, 1'b0, 6'd9, 1'b0);
    expect_out("match_not_used", O_RUN);

    next_cycle();
    drive_ex(6'd0, 1'b1, 1'b1);
    drive_id(6'd0, 1'b1, 6'd0, 1'b1);
    expect_out("lw_x0", O_RUN);

    next_cycle();
    drive_ex(6'd5, 1'b0, 1'b1);
    drive_id(6'd5, 1'b1, 6'd1, 1'b0);
    expect_out("add_not_load", O_RUN);

    next_cycle();
    drive_ex(6'd5, 1'b1, 1'b0);
    expect_out("lw_no_regwrite", O_RUN);

    // redirect beats a simultaneous load-use hazard
    next_cycle();
    drive_ex(6'd5, 1'b1, 1'b1);
    ex_redirect = 1'b1;
    expect_out("redirect_hazard", O_REDIR);
    next_cycle();
    drive_idle();
    expect_out("post_redirect", O_RUN);

`ifdef HAZARD_FPU_MULTICYCLE_EN
    // FPU wait, latency 4: hold at T, T+1, T+2; released at T+3
    next_cycle();
    ex_fpu_start = 1'b1;
    expect_out("fpu_T", O_HOLD);
    next_cycle();
    ex_redirect = 1'b1;
    drive_ex(6'd5, 1'b1, 1'b1);
    drive_id(6'd5, 1'b1, 6'd0, 1'b0);
    expect_out("fpu_T1_ignore", O_HOLD);
    check("fpu_state_wait", {7'd0, dbg_state}, {7'd0, FPU_WAIT});
    next_cycle();
    expect_out("fpu_T2_ignore", O_HOLD);
    next_cycle();
    ex_redirect = 1'b0;
    drive_ex(6'd0, 1'b0, 1'b0);
    expect_out("fpu_T3_release", O_RUN);
    check("fpu_state_run", {7'd0, dbg_state}, {7'd0, RUN});
    next_cycle();
    drive_ex(6'd5, 1'b1, 1'b1);
    ex_fpu_start = 1'b0;
    expect_out("fpu_T4_reeval", O_STALL);

    // illegal fpu+redirect: redirect wins, no wait
    next_cycle();
    drive_idle();
    ex_fpu_start = 1'b1;
    ex_redirect  = 1'b1;
    expect_out("fpu_redirect", O_REDIR);
    next_cycle();
    drive_idle();
    expect_out("fpu_redirect_nowait", O_RUN);

    // reset mid-wait
    next_cycle();
    ex_fpu_start = 1'b1;
    expect_out("fpu2_T", O_HOLD);
    next_cycle();
    rst_n = 1'b0;
    expect_out("fpu2_reset", O_RST);
    next_cycle();
    rst_n = 1'b1;
    ex_fpu_start = 1'b0;
    expect_out("fpu2_released", O_RUN);
    next_cycle();
    expect_out("fpu2_no_residual", O_RUN);
`else
    // single-cycle FPU: no hold at all
    next_cycle();
    ex_fpu_start = 1'b1;
    expect_out("fpu_single_T", O_RUN);
    next_cycle();
    expect_out("fpu_single_T1", O_RUN);
    next_cycle();
    drive_ex(6'd5, 1'b1, 1'b1);
    drive_id(6'd5, 1'b1, 6'd0, 1'b0);
    expect_out("fpu_single_loaduse", O_STALL);
    next_cycle();
    drive_idle();
    expect_out("fpu_single_done", O_RUN);
    check("fpu_single_state", {7'd0, dbg_state}, {7'd0, RUN});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
